// File: rtl/vme_bus_arbiter_if.sv
// Signal bundle shared by the two requesters, the arbiter and the register-bank bus.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface vme_bus_arbiter_if #(
    parameter int AW = 18,
    parameter int DW = 32
);
    logic [AW-1:0] M0Addr;
    logic [DW-1:0] M0WrData;
    logic          M0RdMem;
    logic          M0WrMem;
    logic [DW-1:0] M0RdData;
    logic          M0RdDone;
    logic          M0WrDone;
    logic          M0RdError;
    logic          M0WrError;

    logic [AW-1:0] M1Addr;
    logic [DW-1:0] M1WrData;
    logic          M1RdMem;
    logic          M1WrMem;
    logic [DW-1:0] M1RdData;
    logic          M1RdDone;
    logic          M1WrDone;
    logic          M1RdError;
    logic          M1WrError;

    logic [AW-1:0] VMEAddr;
    logic [DW-1:0] VMEWrData;
    logic          VMERdMem;
    logic          VMEWrMem;
    logic [DW-1:0] VMERdData;
    logic          VMERdDone;
    logic          VMEWrDone;
    logic          Busy;

    modport slave (
        input  M0Addr, M0WrData, M0RdMem, M0WrMem,
        output M0RdData, M0RdDone, M0WrDone, M0RdError, M0WrError,
        input  M1Addr, M1WrData, M1RdMem, M1WrMem,
        output M1RdData, M1RdDone, M1WrDone, M1RdError, M1WrError,
        output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        input  VMERdData, VMERdDone, VMEWrDone,
        output Busy
    );

    modport master (
        output M0Addr, M0WrData, M0RdMem, M0WrMem,
        input  M0RdData, M0RdDone, M0WrDone, M0RdError, M0WrError,
        output M1Addr, M1WrData, M1RdMem, M1WrMem,
        input  M1RdData, M1RdDone, M1WrDone, M1RdError, M1WrError,
        input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        output VMERdData, VMERdDone, VMEWrDone,
        input  Busy
    );
endinterface

// File: rtl/vme_bus_arbiter.sv
// Two-requester round-robin arbiter for a VME-style register-bank bus: one transaction
// in flight at a time, per-requester pending slot, missing slave done becomes an error.
module vme_bus_arbiter #(
    parameter int AW      = 18,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255   // legal range 1..65535
) (
    input logic              Clk,
    input logic              rst_n,
    vme_bus_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | bus free; grant a pending slot if any
    // ISSUE | one-cycle bus strobe for the granted transaction
    // WAIT  | address/data held, waiting for the matching done or timeout
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [15:0] TC_LOAD = 16'(TIMEOUT - 1);

    state_t state_q, state_d;

    logic [1:0]    req_rd;
    logic [1:0]    req_wr;
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];

    logic [1:0]    slot_valid_q;
    logic [1:0]    slot_rw_q;
    logic [AW-1:0] slot_addr_q  [2];
    logic [DW-1:0] slot_wdata_q [2];

    logic          owner_q;
    logic          rw_q;
    logic          last_grant_q;
    logic [15:0]   cnt_q;

    logic          grant_en;
    logic          grant_id;
    logic          fin_done;
    logic          fin_timeout;
    logic [1:0]    owns;
    logic [1:0]    consumed;
    logic [1:0]    active;
    logic [1:0]    both;
    logic [1:0]    accept;
    logic [1:0]    reject;

    logic [DW-1:0] rd_data_q [2];
    logic [1:0]    rd_done_q;
    logic [1:0]    wr_done_q;
    logic [1:0]    rd_err_q;
    logic [1:0]    wr_err_q;
    logic [AW-1:0] vme_addr_q;
    logic [DW-1:0] vme_wdata_q;
    logic          vme_rd_q;
    logic          vme_wr_q;

    assign req_rd       = {bus.M1RdMem, bus.M0RdMem};
    assign req_wr       = {bus.M1WrMem, bus.M0WrMem};
    assign req_addr[0]  = bus.M0Addr;
    assign req_addr[1]  = bus.M1Addr;
    assign req_wdata[0] = bus.M0WrData;
    assign req_wdata[1] = bus.M1WrData;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Done is checked before the terminal count so a same-cycle ack still succeeds.
    always_comb begin
        state_d     = state_q;
        grant_en    = 1'b0;
        grant_id    = 1'b0;
        fin_done    = 1'b0;
        fin_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (|slot_valid_q) begin
                    grant_en = 1'b1;
                    grant_id = (&slot_valid_q) ? ~last_grant_q : slot_valid_q[1];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (rw_q ? bus.VMEWrDone : bus.VMERdDone) begin
                    fin_done = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == 16'd0) begin
                    fin_timeout = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A slot being consumed this edge may be reloaded by a strobe on the same edge.
    always_comb begin
        owns     = '0;
        consumed = '0;
        active   = '0;
        both     = '0;
        accept   = '0;
        reject   = '0;
        for (int i = 0; i < 2; i++) begin
            owns[i]     = (owner_q == 1'(i));
            consumed[i] = grant_en && (grant_id == 1'(i));
            active[i]   = (state_q != IDLE) && owns[i];
            both[i]     = req_rd[i] && req_wr[i];
            reject[i]   = (req_rd[i] ^ req_wr[i]) &&
                          ((slot_valid_q[i] && !consumed[i]) || active[i]);
            accept[i]   = (req_rd[i] ^ req_wr[i]) && !reject[i];
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_q <= '0;
            slot_rw_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                slot_addr_q[i]  <= '0;
                slot_wdata_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    slot_valid_q[i] <= 1'b1;
                    slot_rw_q[i]    <= req_wr[i];
                    slot_addr_q[i]  <= req_addr[i];
                    if (req_wr[i]) begin
                        slot_wdata_q[i] <= req_wdata[i];
                    end
                end else if (consumed[i]) begin
                    slot_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= 1'b0;
            rw_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            vme_addr_q   <= '0;
            vme_wdata_q  <= '0;
            vme_rd_q     <= 1'b0;
            vme_wr_q     <= 1'b0;
        end else begin
            vme_rd_q <= 1'b0;
            vme_wr_q <= 1'b0;
            if (grant_en) begin
                owner_q      <= grant_id;
                rw_q         <= slot_rw_q[grant_id];
                last_grant_q <= grant_id;
                vme_addr_q   <= slot_addr_q[grant_id];
                vme_wdata_q  <= slot_wdata_q[grant_id];
                vme_rd_q     <= !slot_rw_q[grant_id];
                vme_wr_q     <= slot_rw_q[grant_id];
            end
            if (state_q == ISSUE) begin
                cnt_q <= TC_LOAD;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 16'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_done_q <= '0;
            wr_done_q <= '0;
            rd_err_q  <= '0;
            wr_err_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rd_done_q[i] <= fin_done && !rw_q && owns[i];
                wr_done_q[i] <= fin_done && rw_q && owns[i];
                rd_err_q[i]  <= both[i] || (reject[i] && req_rd[i]) ||
                                (fin_timeout && !rw_q && owns[i]);
                wr_err_q[i]  <= both[i] || (reject[i] && req_wr[i]) ||
                                (fin_timeout && rw_q && owns[i]);
                if (fin_done && !rw_q && owns[i]) begin
                    rd_data_q[i] <= bus.VMERdData;
                end
            end
        end
    end

    assign bus.M0RdData  = rd_data_q[0];
    assign bus.M0RdDone  = rd_done_q[0];
    assign bus.M0WrDone  = wr_done_q[0];
    assign bus.M0RdError = rd_err_q[0];
    assign bus.M0WrError = wr_err_q[0];
    assign bus.M1RdData  = rd_data_q[1];
    assign bus.M1RdDone  = rd_done_q[1];
    assign bus.M1WrDone  = wr_done_q[1];
    assign bus.M1RdError = rd_err_q[1];
    assign bus.M1WrError = wr_err_q[1];
    assign bus.VMEAddr   = vme_addr_q;
    assign bus.VMEWrData = vme_wdata_q;
    assign bus.VMERdMem  = vme_rd_q;
    assign bus.VMEWrMem  = vme_wr_q;
    assign bus.Busy      = (state_q != IDLE) || (|slot_valid_q);

    a_one_strobe : assert property (@(posedge Clk) disable iff (!rst_n)
        !(vme_rd_q && vme_wr_q));
    a_strobe_pulse : assert property (@(posedge Clk) disable iff (!rst_n)
        (vme_rd_q || vme_wr_q) |=> !(vme_rd_q || vme_wr_q));
endmodule
